// File: rtl/box_overlay_pkg.sv
// Shared video definitions: coordinate width, box-tracker FSM states,
// RGB565 colour constants and the per-axis border helper.
package box_overlay_pkg;

    localparam int unsigned CoordW = 12;
    localparam int unsigned HoldW  = 4;

    typedef logic [CoordW-1:0] coord_t;

    typedef enum logic [1:0] {
        StNoBox = 2'd0,
        StTrack = 2'd1,
        StHold  = 2'd2
    } box_state_e;

    localparam logic [15:0] Rgb565Black = 16'h0000;
    localparam logic [15:0] Rgb565Red   = 16'hF800;
    localparam logic [15:0] Rgb565Green = 16'h07E0;
    localparam logic [15:0] Rgb565Blue  = 16'h001F;
    localparam logic [15:0] Rgb565White = 16'hFFFF;

    // True when c lies within lw pixels of either end of [lo, hi].
    // Coordinates are at most 11 bits and lw at most 8, so 12-bit sums never wrap.
    function automatic logic axis_edge(coord_t c, coord_t lo, coord_t hi, coord_t lw);
        return (c < lo + lw) || (c + lw > hi);
    endfunction

endpackage

// File: rtl/raster_cnt.sv
// Raster position counter: tracks the (x, y) of the current qualified pixel
// and flags the last pixel of a line and of a frame.
module raster_cnt
    import box_overlay_pkg::*;
#(
    parameter int unsigned ROW_CNT = 1024,
    parameter int unsigned COL_CNT = 768
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   advance_i,
    output coord_t cnt_x_o,
    output coord_t cnt_y_o,
    output logic   eol_o,
    output logic   eof_o
);

    coord_t cnt_x_q, cnt_x_d;
    coord_t cnt_y_q, cnt_y_d;
    logic   last_x;
    logic   last_y;

    assign last_x  = (cnt_x_q == coord_t'(ROW_CNT - 1));
    assign last_y  = (cnt_y_q == coord_t'(COL_CNT - 1));
    assign eol_o   = advance_i && last_x;
    assign eof_o   = advance_i && last_x && last_y;
    assign cnt_x_o = cnt_x_q;
    assign cnt_y_o = cnt_y_q;

    // Next position: step x per pixel, wrap x and step y at end of line.
    always_comb begin
        cnt_x_d = cnt_x_q;
        cnt_y_d = cnt_y_q;
        if (advance_i) begin
            if (last_x) begin
                cnt_x_d = '0;
                cnt_y_d = last_y ? '0 : cnt_y_q + coord_t'(1);
            end else begin
                cnt_x_d = cnt_x_q + coord_t'(1);
            end
        end
    end

    // Position registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_x_q <= '0;
            cnt_y_q <= '0;
        end else begin
            cnt_x_q <= cnt_x_d;
            cnt_y_q <= cnt_y_d;
        end
    end

endmodule

// File: rtl/box_overlay.sv
// Draws a detector bounding box onto an RGB565 pixel stream with one cycle
// of latency. The box is latched at end of frame and drawn on the next frame;
// after detection loss the last box is held for HOLD_FRAMES frames.
module box_overlay
    import box_overlay_pkg::*;
#(
    parameter int unsigned ROW_CNT     = 1024,
    parameter int unsigned COL_CNT     = 768,
    parameter int unsigned LINE_W      = 2,
    parameter logic [15:0] BOX_COLOR   = Rgb565Red,
    parameter int unsigned HOLD_FRAMES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] pix_in,
    input  logic        data_vaild,
    input  logic [10:0] x_min,
    input  logic [10:0] x_max,
    input  logic [10:0] y_min,
    input  logic [10:0] y_max,
    output logic [15:0] pix_out,
    output logic        pix_out_vaild,
    output logic        frame_done,
    output logic        box_active
);

    coord_t cnt_x;
    coord_t cnt_y;
    logic   eol;
    logic   eof;

    raster_cnt #(
        .ROW_CNT(ROW_CNT),
        .COL_CNT(COL_CNT)
    ) u_raster_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .advance_i(data_vaild),
        .cnt_x_o  (cnt_x),
        .cnt_y_o  (cnt_y),
        .eol_o    (eol),
        .eof_o    (eof)
    );

    box_state_e       state_q, state_d;
    logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
    coord_t           bx_min_q, bx_max_q, by_min_q, by_max_q;
    logic             load_box;
    logic             box_valid;
    coord_t           in_x_min, in_x_max, in_y_min, in_y_max;

    assign in_x_min = {1'b0, x_min};
    assign in_x_max = {1'b0, x_max};
    assign in_y_min = {1'b0, y_min};
    assign in_y_max = {1'b0, y_max};

    assign box_valid = (in_x_min <= in_x_max) && (in_y_min <= in_y_max) &&
                       (in_x_max < coord_t'(ROW_CNT)) && (in_y_max < coord_t'(COL_CNT));

    // Tracker next state; decisions are taken only on the last pixel of a frame.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        load_box   = 1'b0;
        if (eof) begin
            unique case (state_q)
                StNoBox: begin
                    if (box_valid) begin
                        state_d  = StTrack;
                        load_box = 1'b1;
                    end
                end
                StTrack: begin
                    if (box_valid) begin
                        load_box = 1'b1;
                    end else begin
                        state_d    = StHold;
                        hold_cnt_d = HoldW'(1);
                    end
                end
                StHold: begin
                    if (box_valid) begin
                        state_d    = StTrack;
                        load_box   = 1'b1;
                        hold_cnt_d = '0;
                    end else if (hold_cnt_q == HoldW'(HOLD_FRAMES)) begin
                        state_d    = StNoBox;
                        hold_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HoldW'(1);
                    end
                end
                default: begin
                    state_d    = StNoBox;
                    hold_cnt_d = '0;
                end
            endcase
        end
    end

    // Tracker state and hold counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StNoBox;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // Shadow box: only updated at end of frame so a frame is drawn with one box.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bx_min_q <= '0;
            bx_max_q <= '0;
            by_min_q <= '0;
            by_max_q <= '0;
        end else if (load_box) begin
            bx_min_q <= in_x_min;
            bx_max_q <= in_x_max;
            by_min_q <= in_y_min;
            by_max_q <= in_y_max;
        end
    end

    assign box_active = (state_q != StNoBox);

    logic   in_box;
    logic   on_edge;
    logic   border_hit;
    coord_t line_w;

    assign line_w = coord_t'(LINE_W);

    // Border test for the current pixel; thin boxes naturally become solid fills.
    always_comb begin
        in_box  = (cnt_x >= bx_min_q) && (cnt_x <= bx_max_q) &&
                  (cnt_y >= by_min_q) && (cnt_y <= by_max_q);
        on_edge = axis_edge(cnt_x, bx_min_q, bx_max_q, line_w) ||
                  axis_edge(cnt_y, by_min_q, by_max_q, line_w);
        border_hit = in_box && on_edge && box_active;
    end

    // Output pipeline stage; pixels outside the qualifier pass through untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_out       <= '0;
            pix_out_vaild <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            pix_out       <= (data_vaild && border_hit) ? BOX_COLOR : pix_in;
            pix_out_vaild <= data_vaild;
            frame_done    <= eof;
        end
    end

endmodule

// File: tb/tb_box_overlay.sv
// Directed bench for box_overlay on a small 16x12 raster.
module tb_box_overlay;

    localparam int ROW = 16;
    localparam int COL = 12;
    localparam int LW = 2;
    localparam int HOLDN = 4;
    localparam int FR = ROW * COL;
    localparam logic [15:0] COLOR = 16'hF800;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pix_in = '0;
    logic        data_vaild = 1'b0;
    logic [10:0] x_min = 11'd1024, x_max = '0, y_min = 11'd1024, y_max = '0;
    logic [15:0] pix_out;
    logic        pix_out_vaild;
    logic        frame_done;
    logic        box_active;

    int total = 0;
    int bad = 0;

    // Results of the last run_pixels call.
    int r_pbad, r_ncol, r_nout, r_vbad, r_nfd, r_fdbad;
    logic r_act;

    box_overlay #(
        .ROW_CNT(ROW),
        .COL_CNT(COL),
        .LINE_W(LW),
        .BOX_COLOR(COLOR),
        .HOLD_FRAMES(HOLDN)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pix_in(pix_in),
        .data_vaild(data_vaild),
        .x_min(x_min),
        .x_max(x_max),
        .y_min(y_min),
        .y_max(y_max),
        .pix_out(pix_out),
        .pix_out_vaild(pix_out_vaild),
        .frame_done(frame_done),
        .box_active(box_active)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] exp_pix(int x, int y, bit act, int x0, int x1, int y0,
                                            int y1, logic [15:0] pin);
        bit inside_b;
        bit near_edge;
        inside_b  = (x >= x0) && (x <= x1) && (y >= y0) && (y <= y1);
        near_edge = (x - x0 < LW) || (x1 - x < LW) || (y - y0 < LW) || (y1 - y < LW);
        return (act && inside_b && near_edge) ? COLOR : pin;
    endfunction

    // Streams npix pixels from (0,0) with detector inputs held at (ix0..iy1),
    // collecting mismatch statistics against the box the frame should show.
    task automatic run_pixels(input int npix, input bit gaps, input int ix0, input int ix1,
                              input int iy0, input int iy1, input bit eact, input int ex0,
                              input int ex1, input int ey0, input int ey1);
        int x = 0, y = 0, sent = 0, cyc = 0;
        logic v;
        logic [15:0] pin, epix;
        bit last;
        r_pbad = 0; r_ncol = 0; r_nout = 0; r_vbad = 0; r_nfd = 0; r_fdbad = 0; r_act = 1'bx;
        x_min = 11'(ix0); x_max = 11'(ix1); y_min = 11'(iy0); y_max = 11'(iy1);
        while (sent < npix && cyc < npix * 8 + 16) begin
            @(negedge clk);
            if (cyc == 0) r_act = box_active;
            v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            pin = 16'(x * 37 + y * 101 + 256);
            data_vaild = v;
            pix_in = pin;
            epix = exp_pix(x, y, eact, ex0, ex1, ey0, ey1, pin);
            last = v && (x == ROW - 1) && (y == COL - 1);
            @(posedge clk);
            #1;
            if (pix_out_vaild !== v) r_vbad++;
            if (v) begin
                r_nout++;
                if (pix_out !== epix) r_pbad++;
                if (pix_out === COLOR) r_ncol++;
            end
            if (frame_done === 1'b1) r_nfd++;
            if (frame_done !== last) r_fdbad++;
            if (v) begin
                sent++;
                if (x == ROW - 1) begin
                    x = 0;
                    y = (y == COL - 1) ? 0 : y + 1;
                end else begin
                    x++;
                end
            end
            cyc++;
        end
        data_vaild = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        data_vaild = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (pix_out !== 16'h0) begin bad++; $display("FAIL rst_pix_out: got %h want 0000", pix_out); end
        total++; if (pix_out_vaild !== 1'b0) begin bad++; $display("FAIL rst_out_vaild: got %b want 0", pix_out_vaild); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_frame_done: got %b want 0", frame_done); end
        total++; if (box_active !== 1'b0) begin bad++; $display("FAIL rst_box_active: got %b want 0", box_active); end
        rst_n = 1'b1;
    endtask

    task automatic test_box_draw();
        apply_reset();
        run_pixels(FR, 0, 3, 12, 2, 9, 0, 0, 0, 0, 0);
        total++; if (r_act !== 1'b0) begin bad++; $display("FAIL draw_f1_active: got %b want 0", r_act); end
        total++; if (r_ncol !== 0) begin bad++; $display("FAIL draw_f1_colour: got %0d want 0", r_ncol); end
        total++; if (r_pbad !== 0) begin bad++; $display("FAIL draw_f1_pixels: got %0d bad want 0", r_pbad); end
        total++; if (r_nfd !== 1 || r_fdbad !== 0) begin bad++; $display("FAIL draw_f1_frame_done: got %0d pulses %0d misaligned want 1/0", r_nfd, r_fdbad); end
        run_pixels(FR, 0, 3, 12, 2, 9, 1, 3, 12, 2, 9);
        total++; if (r_act !== 1'b1) begin bad++; $display("FAIL draw_f2_active: got %b want 1", r_act); end
        total++; if (r_ncol !== 56) begin bad++; $display("FAIL draw_f2_colour: got %0d want 56", r_ncol); end
        total++; if (r_pbad !== 0) begin bad++; $display("FAIL draw_f2_pixels: got %0d bad want 0", r_pbad); end
    endtask

    task automatic test_boundary();
        apply_reset();
        run_pixels(FR, 0, 3, 16, 2, 9, 0, 0, 0, 0, 0);
        run_pixels(FR, 0, 0, 15, 0, 11, 0, 0, 0, 0, 0);
        total++; if (r_act !== 1'b0) begin bad++; $display("FAIL bound_xmax_eq_row_active: got %b want 0", r_act); end
        total++; if (r_ncol !== 0) begin bad++; $display("FAIL bound_xmax_eq_row_colour: got %0d want 0", r_ncol); end
        run_pixels(FR, 0, 1024, 0, 1024, 0, 1, 0, 15, 0, 11);
        total++; if (r_ncol !== 96) begin bad++; $display("FAIL bound_full_frame_colour: got %0d want 96", r_ncol); end
        total++; if (r_pbad !== 0) begin bad++; $display("FAIL bound_full_frame_pixels: got %0d bad want 0", r_pbad); end
    endtask

    task automatic test_hold();
        apply_reset();
        run_pixels(FR, 0, 3, 12, 2, 9, 0, 0, 0, 0, 0);
        run_pixels(FR, 0, 3, 12, 2, 9, 1, 3, 12, 2, 9);
        // Track frame with detection lost, then HOLDN held frames.
        for (int f = 0; f <= HOLDN; f++) begin
            run_pixels(FR, 0, 1024, 0, 1024, 0, 1, 3, 12, 2, 9);
            total++; if (r_act !== 1'b1) begin bad++; $display("FAIL hold_f%0d_active: got %b want 1", f, r_act); end
            total++; if (r_ncol !== 56 || r_pbad !== 0) begin bad++; $display("FAIL hold_f%0d_draw: got %0d colour %0d bad want 56/0", f, r_ncol, r_pbad); end
        end
        run_pixels(FR, 0, 1024, 0, 1024, 0, 0, 0, 0, 0, 0);
        total++; if (r_act !== 1'b0) begin bad++; $display("FAIL hold_expired_active: got %b want 0", r_act); end
        total++; if (r_ncol !== 0) begin bad++; $display("FAIL hold_expired_colour: got %0d want 0", r_ncol); end
    endtask

    task automatic test_hold_change();
        apply_reset();
        run_pixels(FR, 0, 3, 12, 2, 9, 0, 0, 0, 0, 0);
        run_pixels(FR, 0, 1024, 0, 1024, 0, 1, 3, 12, 2, 9);
        run_pixels(FR, 0, 1024, 0, 1024, 0, 1, 3, 12, 2, 9);
        run_pixels(FR, 0, 1024, 0, 1024, 0, 1, 3, 12, 2, 9);
        // Hold count is 3 here; a new valid box returns to tracking.
        run_pixels(FR, 0, 6, 9, 1, 10, 1, 3, 12, 2, 9);
        total++; if (r_ncol !== 56) begin bad++; $display("FAIL chg_old_box_colour: got %0d want 56", r_ncol); end
        run_pixels(FR, 0, 1024, 0, 1024, 0, 1, 6, 9, 1, 10);
        total++; if (r_act !== 1'b1) begin bad++; $display("FAIL chg_new_active: got %b want 1", r_act); end
        total++; if (r_ncol !== 40) begin bad++; $display("FAIL chg_new_solid_colour: got %0d want 40", r_ncol); end
        total++; if (r_pbad !== 0) begin bad++; $display("FAIL chg_new_pixels: got %0d bad want 0", r_pbad); end
        run_pixels(FR, 0, 1024, 0, 1024, 0, 1, 6, 9, 1, 10);
        total++; if (r_act !== 1'b1 || r_ncol !== 40) begin bad++; $display("FAIL chg_hold_after_track: got act %b colour %0d want 1/40", r_act, r_ncol); end
    endtask

    task automatic test_single_pixel();
        apply_reset();
        run_pixels(FR, 0, 10, 10, 10, 10, 0, 0, 0, 0, 0);
        for (int f = 0; f < 2; f++) begin
            run_pixels(FR, 0, 10, 10, 10, 10, 1, 10, 10, 10, 10);
            total++; if (r_ncol !== 1) begin bad++; $display("FAIL single_f%0d_colour: got %0d want 1", f, r_ncol); end
            total++; if (r_pbad !== 0) begin bad++; $display("FAIL single_f%0d_pixels: got %0d bad want 0", f, r_pbad); end
        end
    endtask

    task automatic test_gaps();
        apply_reset();
        run_pixels(FR, 1, 3, 12, 2, 9, 0, 0, 0, 0, 0);
        total++; if (r_nout !== FR || r_vbad !== 0) begin bad++; $display("FAIL gaps_f1_valid: got %0d pixels %0d misaligned want %0d/0", r_nout, r_vbad, FR); end
        total++; if (r_nfd !== 1 || r_fdbad !== 0) begin bad++; $display("FAIL gaps_f1_frame_done: got %0d pulses %0d misaligned want 1/0", r_nfd, r_fdbad); end
        run_pixels(FR, 1, 3, 12, 2, 9, 1, 3, 12, 2, 9);
        total++; if (r_nout !== FR || r_vbad !== 0) begin bad++; $display("FAIL gaps_f2_valid: got %0d pixels %0d misaligned want %0d/0", r_nout, r_vbad, FR); end
        total++; if (r_ncol !== 56 || r_pbad !== 0) begin bad++; $display("FAIL gaps_f2_draw: got %0d colour %0d bad want 56/0", r_ncol, r_pbad); end
        total++; if (r_nfd !== 1) begin bad++; $display("FAIL gaps_f2_frame_done: got %0d pulses want 1", r_nfd); end
    endtask

    task automatic test_reset_mid_frame();
        apply_reset();
        run_pixels(FR, 0, 3, 12, 2, 9, 0, 0, 0, 0, 0);
        // Stop right after pixel (4,7), which sits on the left border.
        run_pixels(7 * ROW + 5, 0, 3, 12, 2, 9, 1, 3, 12, 2, 9);
        total++; if (r_pbad !== 0 || r_fdbad !== 0) begin bad++; $display("FAIL mid_partial: got %0d bad %0d frame_done want 0/0", r_pbad, r_fdbad); end
        rst_n = 1'b0;
        #1;
        total++; if (pix_out !== 16'h0 || pix_out_vaild !== 1'b0) begin bad++; $display("FAIL mid_rst_outputs: got %h/%b want 0000/0", pix_out, pix_out_vaild); end
        total++; if (box_active !== 1'b0 || frame_done !== 1'b0) begin bad++; $display("FAIL mid_rst_flags: got %b/%b want 0/0", box_active, frame_done); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_pixels(FR, 0, 1024, 0, 1024, 0, 0, 0, 0, 0, 0);
        total++; if (r_act !== 1'b0 || r_pbad !== 0) begin bad++; $display("FAIL mid_after_state: got act %b bad %0d want 0/0", r_act, r_pbad); end
        total++; if (r_nfd !== 1 || r_fdbad !== 0) begin bad++; $display("FAIL mid_after_origin: got %0d pulses %0d misaligned want 1/0", r_nfd, r_fdbad); end
    endtask

    initial begin
        test_reset();
        test_box_draw();
        test_boundary();
        test_hold();
        test_hold_change();
        test_single_pixel();
        test_gaps();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
